// File: rtl/sprite_draw_sequencer.sv
// Sprite draw sequencer: holds the host-written sprite attribute table and,
// once per frame, walks it, advances each valid sprite by one motion step
// with edge bounce, and hands it to draw_sprite one at a time.
module sprite_draw_sequencer #(
    parameter int N_SPRITES  = 16,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int SPRITE_DIM = 8,
    localparam int IW        = $clog2(N_SPRITES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tbl_we,
    input  logic [IW-1:0] tbl_addr,
    input  logic [35:0]   tbl_wdata,
    input  logic          frame_start,
    input  logic          done,
    output logic          start,
    output logic [18:0]   coordinates,
    output logic [7:0]    img_sel,
    output logic          busy,
    output logic          frame_done,
    output logic          overrun
);

    localparam logic [10:0] X_MAX = 11'(SCREEN_W - SPRITE_DIM);
    localparam logic [10:0] Y_MAX = 11'(SCREEN_H - SPRITE_DIM);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        MOVE  = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        NEXT  = 3'd5
    } state_t;

    state_t         state_r, state_s;
    logic [35:0]    tbl_r [N_SPRITES];
    logic [IW-1:0]  idx_r, idx_s;
    logic           busy_r, busy_s;
    logic           start_r, start_s;
    logic           frame_done_r, frame_done_s;
    logic           overrun_r, overrun_s;
    logic [18:0]    coord_r, coord_s;
    logic [7:0]     img_sel_r, img_sel_s;
    logic           latch_s, move_s, wb_en_s;

    // Working copy of the entry being processed
    logic [7:0]     w_img_r;
    logic [9:0]     w_x_r;
    logic [8:0]     w_y_r;
    logic [3:0]     w_dx_r, w_dy_r;
    // Host rewrote the current entry in the same cycle it was fetched
    logic           host_hit_r;

    logic [10:0]    nx_s, ny_s;
    logic [9:0]     mx_s;
    logic [8:0]     my_s;
    logic [3:0]     mdx_s, mdy_s;
    logic [35:0]    wb_data_s;

    // One motion step with bounce at the screen edges (11-bit arithmetic)
    always_comb begin
        nx_s  = {1'b0, w_x_r} + {{7{w_dx_r[3]}}, w_dx_r};
        ny_s  = {2'b00, w_y_r} + {{7{w_dy_r[3]}}, w_dy_r};
        mx_s  = w_x_r;
        mdx_s = w_dx_r;
        my_s  = w_y_r;
        mdy_s = w_dy_r;
        if (nx_s[10]) begin
            mx_s  = 10'd0;
            mdx_s = 4'd0 - w_dx_r;
        end else if (nx_s > X_MAX) begin
            mx_s  = X_MAX[9:0];
            mdx_s = 4'd0 - w_dx_r;
        end else begin
            mx_s  = nx_s[9:0];
        end
        if (ny_s[10]) begin
            my_s  = 9'd0;
            mdy_s = 4'd0 - w_dy_r;
        end else if (ny_s > Y_MAX) begin
            my_s  = Y_MAX[8:0];
            mdy_s = 4'd0 - w_dy_r;
        end else begin
            my_s  = ny_s[8:0];
        end
        wb_data_s = {1'b1, w_img_r, mx_s, my_s, mdx_s, mdy_s};
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        busy_s       = busy_r;
        start_s      = 1'b0;
        frame_done_s = 1'b0;
        overrun_s    = overrun_r;
        coord_s      = coord_r;
        img_sel_s    = img_sel_r;
        latch_s      = 1'b0;
        move_s       = 1'b0;
        wb_en_s      = 1'b0;
        if (frame_start && (state_r != IDLE)) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = overrun_r;
        end
        case (state_r)
            IDLE: begin
                if (frame_start) begin
                    busy_s  = 1'b1;
                    idx_s   = '0;
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                latch_s = 1'b1;
                if (tbl_r[idx_r][35]) begin
                    state_s = MOVE;
                end else begin
                    state_s = NEXT;
                end
            end
            MOVE: begin
                move_s    = 1'b1;
                wb_en_s   = ~host_hit_r;
                start_s   = 1'b1;
                coord_s   = 19'(my_s) * 19'(SCREEN_W) + 19'(mx_s);
                img_sel_s = w_img_r;
                state_s   = ISSUE;
            end
            ISSUE: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (done) begin
                    state_s = NEXT;
                end else begin
                    state_s = WAIT;
                end
            end
            NEXT: begin
                if (idx_r == IW'(N_SPRITES - 1)) begin
                    frame_done_s = 1'b1;
                    busy_s       = 1'b0;
                    state_s      = IDLE;
                end else begin
                    idx_s   = idx_r + 1'b1;
                    state_s = FETCH;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // Registered outputs, index and working copy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r        <= '0;
            busy_r       <= 1'b0;
            start_r      <= 1'b0;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
            coord_r      <= 19'd0;
            img_sel_r    <= 8'd0;
            w_img_r      <= 8'd0;
            w_x_r        <= 10'd0;
            w_y_r        <= 9'd0;
            w_dx_r       <= 4'd0;
            w_dy_r       <= 4'd0;
            host_hit_r   <= 1'b0;
        end else begin
            idx_r        <= idx_s;
            busy_r       <= busy_s;
            start_r      <= start_s;
            frame_done_r <= frame_done_s;
            overrun_r    <= overrun_s;
            coord_r      <= coord_s;
            img_sel_r    <= img_sel_s;
            if (latch_s) begin
                w_img_r    <= tbl_r[idx_r][34:27];
                w_x_r      <= tbl_r[idx_r][26:17];
                w_y_r      <= tbl_r[idx_r][16:8];
                w_dx_r     <= tbl_r[idx_r][7:4];
                w_dy_r     <= tbl_r[idx_r][3:0];
                host_hit_r <= tbl_we && (tbl_addr == idx_r);
            end
            if (move_s) begin
                w_x_r  <= mx_s;
                w_y_r  <= my_s;
                w_dx_r <= mdx_s;
                w_dy_r <= mdy_s;
            end
        end
    end

    // Attribute table: a host write beats the motion write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                tbl_r[i] <= 36'd0;
            end
        end else begin
            for (int i = 0; i < N_SPRITES; i++) begin
                if (tbl_we && (tbl_addr == IW'(i))) begin
                    tbl_r[i] <= tbl_wdata;
                end else if (wb_en_s && (idx_r == IW'(i))) begin
                    tbl_r[i] <= wb_data_s;
                end
            end
        end
    end

    assign start       = start_r;
    assign coordinates = coord_r;
    assign img_sel     = img_sel_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Self-checking bench for sprite_draw_sequencer with a behavioural
// draw_sprite responder and a scoreboard of expected draw requests.
module tb_sprite_draw_sequencer;

    localparam int N = 16;

    logic        clk;
    logic        rst;
    logic        tbl_we;
    logic [3:0]  tbl_addr;
    logic [35:0] tbl_wdata;
    logic        frame_start;
    logic        done;
    logic        start;
    logic [18:0] coordinates;
    logic [7:0]  img_sel;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int draw_delay = 3;

    int m_v [N];
    int m_img [N];
    int m_x [N];
    int m_y [N];
    int m_dx [N];
    int m_dy [N];
    logic [26:0] exp_q [$];

    logic [3:0]  hw_addr;
    logic [35:0] hw_data;

    sprite_draw_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .tbl_we      (tbl_we),
        .tbl_addr    (tbl_addr),
        .tbl_wdata   (tbl_wdata),
        .frame_start (frame_start),
        .done        (done),
        .start       (start),
        .coordinates (coordinates),
        .img_sel     (img_sel),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // draw_sprite stand-in: clears done on start, raises it draw_delay cycles later
    initial begin
        done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (start) begin
                done = 1'b0;
                repeat (draw_delay) @(posedge clk);
                #2;
                done = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int neg4(input int d);
        int r;
        r = -d;
        if (r == 8) r = -8;
        return r;
    endfunction

    task automatic bounce(inout int p, inout int d, input int lim);
        int np;
        np = p + d;
        if (np < 0) begin
            p = 0;
            d = neg4(d);
        end else if (np > lim) begin
            p = lim;
            d = neg4(d);
        end else begin
            p = np;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_img[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dx[i] = 0; m_dy[i] = 0;
        end
        exp_q.delete();
    endtask

    function automatic logic [35:0] pack(input int v, input int img, input int x, input int y,
                                         input int dx, input int dy);
        return {1'(v), 8'(img), 10'(x), 9'(y), 4'(dx), 4'(dy)};
    endfunction

    task automatic write_entry(input int idx, input int v, input int img, input int x,
                               input int y, input int dx, input int dy);
        @(negedge clk);
        tbl_we    = 1'b1;
        tbl_addr  = 4'(idx);
        tbl_wdata = pack(v, img, x, y, dx, dy);
        m_v[idx] = v; m_img[idx] = img; m_x[idx] = x; m_y[idx] = y; m_dx[idx] = dx; m_dy[idx] = dy;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    task automatic predict_frame();
        for (int i = 0; i < N; i++) begin
            if (m_v[i] != 0) begin
                bounce(m_x[i], m_dx[i], 632);
                bounce(m_y[i], m_dy[i], 472);
                exp_q.push_back({8'(m_img[i]), 19'(m_y[i] * 640 + m_x[i])});
            end
        end
    endtask

    // Runs one pass; cyc counts negedges from the frame_start edge to frame_done
    task automatic run_frame(input int mid_fs, input int hw_cyc, output int cyc,
                             output int nst, output int done_cyc);
        int got;
        int armed;
        logic [26:0] e;
        @(negedge clk);
        frame_start = 1'b1;
        cyc = 0; nst = 0; got = 0; armed = 1; done_cyc = -1;
        while (got == 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            frame_start = (cyc == mid_fs) ? 1'b1 : 1'b0;
            if (cyc == hw_cyc) begin
                tbl_we = 1'b1; tbl_addr = hw_addr; tbl_wdata = hw_data;
            end else begin
                tbl_we = 1'b0;
            end
            if (cyc == 1) chk("busy_after_frame_start", 32'(busy), 32'd1);
            if (start) begin
                chk("start_after_prior_done", 32'(armed), 32'd1);
                armed = 0;
                nst++;
                chk("start_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("img_sel", 32'(img_sel), 32'(e[26:19]));
                    chk("coordinates", 32'(coordinates), 32'(e[18:0]));
                end
            end else if (done && armed == 0) begin
                armed = 1;
                done_cyc = cyc;
            end
            if (frame_done) got = 1;
        end
        frame_start = 1'b0;
        tbl_we = 1'b0;
        chk("frame_done_seen", 32'(got), 32'd1);
        chk("busy_clear_at_end", 32'(busy), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic pulse_and_wait_start();
        int seen;
        @(negedge clk);
        frame_start = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            frame_start = 1'b0;
            if (start) seen = 1;
        end
        chk("start_seen", 32'(seen), 32'd1);
    endtask

    int cyc, nst, dcyc;

    initial begin
        rst = 1'b1; tbl_we = 1'b0; tbl_addr = 4'd0; tbl_wdata = 36'd0; frame_start = 1'b0;
        hw_addr = 4'd0; hw_data = 36'd0;
        clear_model();
        repeat (3) @(negedge clk);
        chk("reset_start", 32'(start), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_coordinates", 32'(coordinates), 32'd0);
        chk("reset_img_sel", 32'(img_sel), 32'd0);
        rst = 1'b0;

        // Single sprite, long draw: one start, then 15 invalid entries
        write_entry(0, 1, 8'h05, 100, 50, 2, -1);
        draw_delay = 20;
        predict_frame();
        run_frame(-1, -1, cyc, nst, dcyc);
        chk("t1_start_count", 32'(nst), 32'd1);
        chk("t1_done_to_frame_done", 32'(cyc - dcyc), 32'd32);
        chk("t1_overrun", 32'(overrun), 32'd0);
        draw_delay = 3;
        predict_frame();
        run_frame(-1, -1, cyc, nst, dcyc);
        chk("t1b_start_count", 32'(nst), 32'd1);

        // Edge bounce, saturating dx=-8, sparse table in index order
        write_entry(0, 1, 8'hA0, 5, 200, -8, 7);
        write_entry(5, 1, 8'hA5, 630, 10, 4, 0);
        write_entry(15, 1, 8'hAF, 20, 1, 0, -3);
        for (int f = 0; f < 2; f++) begin
            predict_frame();
            run_frame(-1, -1, cyc, nst, dcyc);
            chk("sparse_start_count", 32'(nst), 32'd3);
            @(negedge clk);
            chk("frame_done_single_pulse", 32'(frame_done), 32'd0);
        end
        chk("overrun_before", 32'(overrun), 32'd0);

        // frame_start mid-pass: pass unchanged, overrun sticky
        predict_frame();
        run_frame(4, -1, cyc, nst, dcyc);
        chk("overrun_set", 32'(overrun), 32'd1);
        predict_frame();
        run_frame(-1, -1, cyc, nst, dcyc);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Host write lands in the MOVE write-back cycle of entry 0
        write_entry(0, 1, 8'h11, 10, 10, 1, 1);
        predict_frame();
        hw_addr = 4'd0;
        hw_data = pack(1, 8'h77, 300, 200, 1, 1);
        m_v[0] = 1; m_img[0] = 8'h77; m_x[0] = 300; m_y[0] = 200; m_dx[0] = 1; m_dy[0] = 1;
        run_frame(-1, 2, cyc, nst, dcyc);
        predict_frame();
        run_frame(-1, -1, cyc, nst, dcyc);
        chk("collision_start_count", 32'(nst), 32'd3);

        // Reset while start is high
        pulse_and_wait_start();
        #1 rst = 1'b1;
        #1;
        chk("rst_issue_start", 32'(start), 32'd0);
        chk("rst_issue_busy", 32'(busy), 32'd0);
        chk("rst_issue_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        repeat (10) @(negedge clk);

        // Empty table timing, then frame_start on the NEXT->IDLE cycle
        run_frame(-1, -1, cyc, nst, dcyc);
        chk("empty_start_count", 32'(nst), 32'd0);
        chk("empty_cycles", 32'(cyc), 32'(2 * N + 1));
        chk("empty_overrun", 32'(overrun), 32'd0);
        run_frame(32, -1, cyc, nst, dcyc);
        chk("last_cycle_cycles", 32'(cyc), 32'(2 * N + 1));
        chk("last_cycle_overrun", 32'(overrun), 32'd1);
        repeat (3) @(negedge clk);
        chk("last_cycle_not_accepted", 32'(busy), 32'd0);

        // Reset while waiting for done
        write_entry(3, 1, 8'h33, 40, 40, 1, 1);
        draw_delay = 50;
        pulse_and_wait_start();
        repeat (3) @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_wait_busy", 32'(busy), 32'd0);
        chk("rst_wait_start", 32'(start), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        repeat (60) @(negedge clk);
        draw_delay = 3;
        run_frame(-1, -1, cyc, nst, dcyc);
        chk("post_rst_start_count", 32'(nst), 32'd0);
        chk("post_rst_cycles", 32'(cyc), 32'(2 * N + 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
